// File: rtl/param_stack_pkg.sv
// Shared types and helpers for the parametrised LIFO.
// Optional feature macro used across this slice: PARAM_STACK_PEEK_EN.
package stack_pkg;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_TOS,
    OP_REPLACE
  } stack_op_e;

  // Occupancy must represent 0..depth inclusive, hence depth+1 states.
  function automatic int calc_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/param_stack_if.sv
// Controller-to-stack bus. PARAM_STACK_PEEK_EN adds the peek_idx/peek_data/peek_oob lines.
interface param_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
);
  import stack_pkg::*;

  localparam int CNT_W = calc_cnt_w(DEPTH);

  // Requests (push/pop/tos) are single-cycle commands sampled on the rising
  // edge; there is no ready. d_valid is a one-cycle strobe in the cycle after
  // a successful pop/tos/replace, and d_out is only meaningful while it is high.
  logic             push;
  logic             pop;
  logic             tos;
  logic [WIDTH-1:0] d_in;
  logic             clr_err;
  logic [WIDTH-1:0] d_out;
  logic             d_valid;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             err_ovf;
  logic             err_unf;
`ifdef PARAM_STACK_PEEK_EN
  logic [CNT_W-1:0] peek_idx;
  logic [WIDTH-1:0] peek_data;
  logic             peek_oob;
`endif

  modport master (
    output push, pop, tos, d_in, clr_err,
`ifdef PARAM_STACK_PEEK_EN
    output peek_idx,
    input  peek_data, peek_oob,
`endif
    input  d_out, d_valid, count, empty, full, err_ovf, err_unf
  );

  modport slave (
    input  push, pop, tos, d_in, clr_err,
`ifdef PARAM_STACK_PEEK_EN
    input  peek_idx,
    output peek_data, peek_oob,
`endif
    output d_out, d_valid, count, empty, full, err_ovf, err_unf
  );

endinterface

// File: rtl/param_stack_mem.sv
// DEPTH x WIDTH stack storage: one write port, one registered read port, optional async peek port.
// The async port exists only when PARAM_STACK_PEEK_EN is defined.
module param_stack_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
`ifdef PARAM_STACK_PEEK_EN
  input  logic [ADDR_W-1:0] peek_addr,
  output logic [WIDTH-1:0]  peek_rdata,
`endif
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] st [DEPTH];

  // Storage is intentionally not reset; occupancy alone decides what is reachable.
  always_ff @(posedge clk) begin
    if (we) st[waddr] <= wdata;
  end

  // Read-before-write on the same address gives the old top during a replace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= st[raddr];
  end

`ifdef PARAM_STACK_PEEK_EN
  assign peek_rdata = st[peek_addr];
`endif

endmodule

// File: rtl/param_stack.sv
// Parametrised operand/return-address LIFO: op decode, occupancy counter and sticky error flags.
// Define PARAM_STACK_PEEK_EN to add the combinational peek port.
module param_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input logic         clk,
  input logic         rst,
  param_stack_if.slave bus
);

  localparam int CNT_W  = calc_cnt_w(DEPTH);
  localparam int ADDR_W = $clog2(DEPTH);

  stack_op_e         op;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              empty_w, full_w;
  logic [ADDR_W-1:0] top_addr, free_addr;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_waddr;
  logic              ovf_ev, unf_ev;
  logic              d_valid_q, err_ovf_q, err_unf_q;

  assign empty_w   = (cnt_q == '0);
  assign full_w    = (cnt_q == CNT_W'(DEPTH));
  assign top_addr  = ADDR_W'(cnt_q - CNT_W'(1));
  assign free_addr = ADDR_W'(cnt_q);

  // Priority decode: push+pop beats push, push beats pop, pop beats tos.
  always_comb begin
    op = OP_IDLE;
    if (bus.push && bus.pop) op = empty_w ? OP_PUSH : OP_REPLACE;
    else if (bus.push)       op = OP_PUSH;
    else if (bus.pop)        op = OP_POP;
    else if (bus.tos)        op = OP_TOS;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = free_addr;
    ovf_ev    = 1'b0;
    unf_ev    = 1'b0;
    cnt_nxt   = cnt_q;
    unique case (op)
      OP_PUSH: begin
        if (full_w) ovf_ev = 1'b1;
        else begin
          mem_we  = 1'b1;
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      OP_REPLACE: begin
        mem_we    = 1'b1;
        mem_waddr = top_addr;
        mem_re    = 1'b1;
      end
      OP_POP: begin
        if (empty_w) unf_ev = 1'b1;
        else begin
          mem_re  = 1'b1;
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      OP_TOS: begin
        if (empty_w) unf_ev = 1'b1;
        else         mem_re = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      d_valid_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_nxt;
      d_valid_q <= mem_re;
      // A new error in the clearing cycle must survive the clear.
      err_ovf_q <= ovf_ev | (err_ovf_q & ~bus.clr_err);
      err_unf_q <= unf_ev | (err_unf_q & ~bus.clr_err);
    end
  end

`ifdef PARAM_STACK_PEEK_EN
  logic [ADDR_W-1:0] peek_addr;
  logic [WIDTH-1:0]  peek_rdata;
  logic              peek_oob_w;

  assign peek_oob_w    = (bus.peek_idx >= cnt_q);
  assign peek_addr     = ADDR_W'(cnt_q - CNT_W'(1) - bus.peek_idx);
  assign bus.peek_oob  = peek_oob_w;
  assign bus.peek_data = peek_oob_w ? '0 : peek_rdata;
`endif

  param_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .we        (mem_we),
    .waddr     (mem_waddr),
    .wdata     (bus.d_in),
    .re        (mem_re),
    .raddr     (top_addr),
`ifdef PARAM_STACK_PEEK_EN
    .peek_addr (peek_addr),
    .peek_rdata(peek_rdata),
`endif
    .rdata     (bus.d_out)
  );

  assign bus.count   = cnt_q;
  assign bus.empty   = empty_w;
  assign bus.full    = full_w;
  assign bus.d_valid = d_valid_q;
  assign bus.err_ovf = err_ovf_q;
  assign bus.err_unf = err_unf_q;

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO for the multicycle datapath: operand/return-address stack with configurable width and depth.
- Adds full/empty/count status, sticky overflow/underflow error flags, a registered output-valid strobe, and a single-cycle push+pop "replace top" operation.
- Sits between the controller FSM (issues push/pop/tos) and the datapath register feeding the ALU/PC mux.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 64, number of entries (>=2, any integer, not restricted to a power of two).
- CNT_W, $clog2(DEPTH+1), width of count; derived, never overridden.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- push  input  1  write d_in onto stack.
- pop  input  1  remove top; returned on d_out.
- tos  input  1  read top without removal.
- d_in  input  WIDTH  push data.
- clr_err  input  1  synchronous clear of sticky error flags.
- d_out  output  WIDTH  registered read data.
- d_valid  output  1  one-cycle strobe: d_out updated this cycle by pop/tos/replace.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- empty  output  1  count==0, combinational from count register.
- full  output  1  count==DEPTH, combinational from count register.
- err_ovf  output  1  sticky: push attempted while full.
- err_unf  output  1  sticky: pop/tos attempted while empty.

Behaviour:
- Reset (async, rst=1): count=0, d_out=0, d_valid=0, err_ovf=0, err_unf=0. Storage array is not reset.
- Storage: entries st[0..DEPTH-1]; top entry = st[count-1]; next free slot = st[count].
- Op decode per cycle, first matching row wins:
  - push&pop, count>0: replace. d_out<=st[count-1], st[count-1]<=d_in, count unchanged, d_valid=1. Legal when full.
  - push&pop, count==0: behaves as plain push. No error, d_valid=0.
  - push, count<DEPTH: st[count]<=d_in, count+1, d_valid=0.
  - push, full: ignored, storage and count unchanged, err_ovf<=1.
  - pop, count>0: d_out<=st[count-1], count-1, d_valid=1.
  - pop, empty: ignored, d_out holds, err_unf<=1, d_valid=0.
  - tos, count>0: d_out<=st[count-1], d_valid=1.
  - tos, empty: d_out holds, err_unf<=1, d_valid=0.
  - idle: d_out holds, d_valid=0.
- tos is ignored whenever push or pop is asserted.
- Latency: read data appears on d_out one clock after the request edge, aligned with d_valid. Data written by push is readable by tos/pop issued on the next cycle.
- clr_err: clears both sticky flags. If an error event occurs in the same cycle, the error wins (flag = 1).
- Status: full/empty/count reflect the post-edge value; no combinational path from the op inputs.
- Reset mid-operation: all ops in flight are discarded and the stack is logically empty; old storage contents are unreachable.
- Counter never wraps: saturation is enforced by the full/empty guards above.

Optional Feature:
- Macro: PARAM_STACK_PEEK_EN.
- Defined: adds input peek_idx [CNT_W-1:0] and output peek_data [WIDTH-1:0].
  - peek_data = st[count-1-peek_idx] when peek_idx<count, combinational; otherwise peek_data=0.
  - Adds output peek_oob = (peek_idx>=count).
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package stack_pkg:
  - typedef stack_op_e {OP_IDLE, OP_PUSH, OP_POP, OP_TOS, OP_REPLACE}.
  - Function computing CNT_W.
- Sub-module param_stack_mem: DEPTH x WIDTH storage with 1 write port, 1 synchronous read port, and 1 async read port for peek.
- param_stack keeps the op decoder, count register, and flags.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33; pop x3 -> d_out 0x33, 0x22, 0x11 on successive cycles, each with d_valid=1; count 3->0; empty=1.
- DEPTH=4: push 5 values -> full=1 after the 4th; 5th ignored, err_ovf=1, count=4; pop returns the 4th value.
- Empty pop and empty tos -> err_unf=1, d_out unchanged, d_valid=0; clr_err next cycle -> err_unf=0. clr_err together with a new empty pop -> err_unf stays 1.
- Stack [0xA0,0xB0]: push&pop with d_in=0xC0 -> d_out=0xB0, d_valid=1, count=2; following tos -> 0xC0. Repeat while full -> no err_ovf.
- Assert rst asynchronously mid-burst of pushes -> count=0, d_out=0, flags=0 immediately; tos after release -> err_unf=1.
- PARAM_STACK_PEEK_EN with [1,2,3] (3 on top): peek_idx=0 -> 3, peek_idx=2 -> 1, peek_idx=3 -> peek_oob=1, peek_data=0.
